fetch_stage: RTL and testbench

Instruction-fetch (F) stage of the 5-stage MIPS pipeline, directly upstream of the D-stage next-PC logic. It holds the program counter, drives the instruction-memory request, and absorbs variable memory latency and hazard stalls. It applies the redirect decided in D, keeping the branch-delay-slot semantics. It owns the IF/ID pipeline register that feeds PC4 and the instruction word (I26 = Instr_D[25:0]) to D.

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/if_id_reg.sv | 32 +++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared control constants for the fetch stage: reset vector, PCSel encodings
// and the word-alignment helper applied to redirect targets.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  localparam logic [1:0] pc_sel_pc4 = 2'd0;
  localparam logic [1:0] pc_sel_npc = 2'd1;
  localparam logic [1:0] pc_sel_rs  = 2'd2;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction word, its PC+4 and a valid flag.
// Loads when enabled; a bubble load clears the word to a nop.
module if_id_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bubble,
  input  logic [31:0] instr,
  input  logic [31:0] pc4,
  output logic [31:0] instr_d,
  output logic [31:0] pc4_d,
  output logic        valid_d
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d <= 32'd0;
      pc4_d   <= 32'd0;
      valid_d <= 1'b0;
    end else if (en) begin
      if (bubble) begin
        instr_d <= 32'd0;
        valid_d <= 1'b0;
      end else begin
        instr_d <= instr;
        pc4_d   <= pc4;
        valid_d <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS F stage: program counter, instruction-memory request, one-word skid
// buffer for stalls, deferred redirect for memory waits, and the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  PCSel,
  input  logic [31:0] NPC_D,
  input  logic [31:0] RS_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_D,
  output logic [31:0] PC4_D,
  output logic        valid_D,
  output logic        align_err
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] ibuf_reg, ibuf_next;
  logic        ibuf_valid_reg, ibuf_valid_next;
  logic [31:0] pend_pc_reg, pend_pc_next;
  logic        pend_valid_reg, pend_valid_next;
  logic        align_err_reg, align_err_next;

  logic        avail;
  logic [31:0] word;
  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] pc4;

  assign avail      = ibuf_valid_reg | imem_ready;
  assign word       = ibuf_valid_reg ? ibuf_reg : imem_rdata;
  assign redirect   = (PCSel == pc_sel_npc) || (PCSel == pc_sel_rs);
  assign target_raw = (PCSel == pc_sel_rs) ? RS_D : NPC_D;
  assign pc4        = pc_reg + 32'd4;

  // A full skid buffer already holds the word for PC_F, so no new request.
  assign imem_req  = !ibuf_valid_reg;
  assign imem_addr = pc_reg;
  assign align_err = align_err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg         <= RESET_PC;
      ibuf_reg       <= 32'd0;
      ibuf_valid_reg <= 1'b0;
      pend_pc_reg    <= 32'd0;
      pend_valid_reg <= 1'b0;
      align_err_reg  <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      ibuf_reg       <= ibuf_next;
      ibuf_valid_reg <= ibuf_valid_next;
      pend_pc_reg    <= pend_pc_next;
      pend_valid_reg <= pend_valid_next;
      align_err_reg  <= align_err_next;
    end
  end

  always_comb begin
    pc_next         = pc_reg;
    ibuf_next       = ibuf_reg;
    ibuf_valid_next = ibuf_valid_reg;
    pend_pc_next    = pend_pc_reg;
    pend_valid_next = pend_valid_reg;
    align_err_next  = align_err_reg;

    if (!stall) begin
      // D re-presents PCSel while stalled, so redirects are only acted on here.
      if (redirect && (target_raw[1:0] != 2'b00))
        align_err_next = 1'b1;
      if (avail) begin
        ibuf_valid_next = 1'b0;
        pend_valid_next = 1'b0;
        if (redirect)
          pc_next = word_align(target_raw);
        else if (pend_valid_reg)
          pc_next = pend_pc_reg;
        else
          pc_next = pc4;
      end else if (redirect) begin
        // Delay slot still outstanding: remember where to go once it arrives.
        pend_pc_next    = word_align(target_raw);
        pend_valid_next = 1'b1;
      end
    end else if (imem_ready && !ibuf_valid_reg) begin
      ibuf_next       = imem_rdata;
      ibuf_valid_next = 1'b1;
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (reset),
    .en      (!stall),
    .bubble  (!avail),
    .instr   (word),
    .pc4     (pc4),
    .instr_d (Instr_D),
    .pc4_d   (PC4_D),
    .valid_d (valid_D)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected IF/ID words,
// a monitor pops them on every non-stalled edge that yields valid_D.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  PCSel = 2'd0;
  logic [31:0] NPC_D = 32'd0;
  logic [31:0] RS_D = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] Instr_D;
  logic [31:0] PC4_D;
  logic        valid_D;
  logic        align_err;
  logic        garble = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Each word is tagged with the low half of its address.
  assign imem_rdata = garble ? 32'hDEAD_BEEF : {16'h2408, imem_addr[15:0]};

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .PCSel      (PCSel),
    .NPC_D      (NPC_D),
    .RS_D       (RS_D),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .Instr_D    (Instr_D),
    .PC4_D      (PC4_D),
    .valid_D    (valid_D),
    .align_err  (align_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: a non-stalled, non-reset edge that leaves valid_D high is a delivery.
  always begin
    logic s, r;
    exp_t e;
    @(posedge clk);
    s = stall;
    r = reset;
    #1;
    if (!s && !r && valid_D) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_delivery: got Instr_D=%h PC4_D=%h expected none", Instr_D, PC4_D);
      end else begin
        e = exp_q.pop_front();
        chk("deliver_instr", Instr_D, e.instr);
        chk("deliver_pc4", PC4_D, e.pc4);
        $display("t=%0t deliver Instr_D=%h PC4_D=%h", $time, Instr_D, PC4_D);
      end
    end
  end

  task automatic cyc(input logic st, input logic rdy, input logic [1:0] sel,
                     input logic [31:0] npc, input logic [31:0] rs,
                     input logic [31:0] exp_addr, input logic push,
                     input logic [31:0] ei, input logic [31:0] ep);
    exp_t e;
    @(negedge clk);
    stall = st; imem_ready = rdy; PCSel = sel; NPC_D = npc; RS_D = rs;
    if (push) begin
      e.instr = ei; e.pc4 = ep;
      exp_q.push_back(e);
    end
    #1 chk("imem_addr", imem_addr, exp_addr);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_bubble(input string name);
    chk(name, {31'd0, valid_D}, 32'd0);
    chk(name, Instr_D, 32'd0);
    $display("t=%0t bubble %s", $time, name);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_addr"}, imem_addr, 32'h0000_3000);
    chk({name, "_req"}, {31'd0, imem_req}, 32'd1);
    chk({name, "_valid"}, {31'd0, valid_D}, 32'd0);
    chk({name, "_instr"}, Instr_D, 32'd0);
    chk({name, "_pc4"}, PC4_D, 32'd0);
    chk({name, "_align"}, {31'd0, align_err}, 32'd0);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("reset");

    // First fetch straight out of reset.
    @(negedge clk);
    reset = 1'b0; imem_ready = 1'b1;
    e.instr = 32'h2408_3000; e.pc4 = 32'h0000_3004; exp_q.push_back(e);
    #1 chk("imem_addr", imem_addr, 32'h0000_3000);
    @(posedge clk); #2;
    chk("first_valid", {31'd0, valid_D}, 32'd1);

    cyc(0, 1, 2'd0, 0, 0, 32'h3004, 1, 32'h2408_3004, 32'h3008);
    // Branch in D with its delay slot at 3008 available.
    cyc(0, 1, 2'd1, 32'h3100, 0, 32'h3008, 1, 32'h2408_3008, 32'h300C);
    cyc(0, 1, 2'd0, 0, 0, 32'h3100, 1, 32'h2408_3100, 32'h3104);

    // Memory wait at 3104 with a jr pulse in the middle.
    cyc(0, 0, 2'd0, 0, 0, 32'h3104, 0, 0, 0);
    chk_bubble("wait1");
    cyc(0, 0, 2'd2, 0, 32'h3200, 32'h3104, 0, 0, 0);
    chk_bubble("wait2");
    cyc(0, 0, 2'd0, 0, 0, 32'h3104, 0, 0, 0);
    chk_bubble("wait3");
    cyc(0, 1, 2'd0, 0, 0, 32'h3104, 1, 32'h2408_3104, 32'h3108);

    // Stall at 3200: word captured in the skid buffer, request drops.
    cyc(1, 1, 2'd0, 0, 0, 32'h3200, 0, 0, 0);
    chk("stall_req_low", {31'd0, imem_req}, 32'd0);
    garble = 1'b1;
    cyc(1, 1, 2'd1, 32'h5000, 0, 32'h3200, 0, 0, 0);
    chk("stall_hold_valid", {31'd0, valid_D}, 32'd1);
    chk("stall_hold_pc4", PC4_D, 32'h3108);
    cyc(0, 0, 2'd0, 0, 0, 32'h3200, 1, 32'h2408_3200, 32'h3204);
    garble = 1'b0;
    chk("post_skid_addr", imem_addr, 32'h3204);
    chk("post_skid_req", {31'd0, imem_req}, 32'd1);
    chk("align_clear", {31'd0, align_err}, 32'd0);

    // Misaligned jr target.
    cyc(0, 1, 2'd2, 0, 32'h3202, 32'h3204, 1, 32'h2408_3204, 32'h3208);
    chk("align_set", {31'd0, align_err}, 32'd1);
    cyc(0, 1, 2'd0, 0, 0, 32'h3200, 1, 32'h2408_3200, 32'h3204);
    chk("align_sticky", {31'd0, align_err}, 32'd1);

    // PC wrap at the top of the address space.
    cyc(0, 1, 2'd1, 32'hFFFF_FFFC, 0, 32'h3204, 1, 32'h2408_3204, 32'h3208);
    cyc(0, 1, 2'd0, 0, 0, 32'hFFFF_FFFC, 1, 32'h2408_FFFC, 32'h0000_0000);
    cyc(0, 1, 2'd0, 0, 0, 32'h0000_0000, 1, 32'h2408_0000, 32'h0000_0004);

    // Build pending redirect and full skid buffer, then reset mid-cycle.
    cyc(0, 0, 2'd1, 32'h3100, 0, 32'h4, 0, 0, 0);
    chk_bubble("pend_bubble");
    cyc(1, 1, 2'd0, 0, 0, 32'h4, 0, 0, 0);
    chk("both_req_low", {31'd0, imem_req}, 32'd0);
    #1 reset = 1'b1;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    stall = 1'b0; imem_ready = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("reset_held");

    @(negedge clk);
    reset = 1'b0;
    e.instr = 32'h2408_3000; e.pc4 = 32'h0000_3004; exp_q.push_back(e);
    #1 chk("restart_addr", imem_addr, 32'h0000_3000);
    @(posedge clk); #2;
    cyc(0, 1, 2'd0, 0, 0, 32'h3004, 1, 32'h2408_3004, 32'h3008);

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
